// File: rtl/ws2812_pkg.sv
// Shared WS2812 timing constants and receiver state encoding.
package ws2812_pkg;

  localparam int unsigned CLK_FRE      = 27_000_000;
  localparam int unsigned WS2812_WIDTH = 24;
  localparam int unsigned T_BIT_THRESH = CLK_FRE / 1_000_000 * 5 / 8;
  localparam int unsigned T_GLITCH     = 3;
  localparam int unsigned T_HIGH_MAX   = CLK_FRE / 1_000_000 * 2;
  localparam int unsigned DELAY_RESET  = CLK_FRE / 1_000_000 * 50;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } ws2812_state_e;

endpackage

// File: rtl/ws2812_sync.sv
// Two-flop synchronizer bringing the asynchronous data line into the clk domain.
module ws2812_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver: decodes pulse widths into an LED word, then forwards the
// remainder of the frame to downstream LEDs.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int unsigned CLK_FRE      = ws2812_pkg::CLK_FRE,
  parameter int unsigned WS2812_WIDTH = ws2812_pkg::WS2812_WIDTH,
  parameter int unsigned T_BIT_THRESH = CLK_FRE / 1_000_000 * 5 / 8,
  parameter int unsigned T_GLITCH     = 3,
  parameter int unsigned T_HIGH_MAX   = CLK_FRE / 1_000_000 * 2,
  parameter int unsigned DELAY_RESET  = CLK_FRE / 1_000_000 * 50
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din,
  output logic                    dout,
  output logic [WS2812_WIDTH-1:0] rgb_data,
  output logic                    data_valid,
  output logic                    frame_done,
  output logic                    bit_err
);

  localparam int unsigned CNT_MAX = (DELAY_RESET > T_HIGH_MAX) ? DELAY_RESET : T_HIGH_MAX;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(WS2812_WIDTH + 1);

  logic din_s;

  ws2812_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (din),
    .q_o (din_s)
  );

  ws2812_state_e           state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [WS2812_WIDTH-1:0] shift_q, shift_d;
  logic [WS2812_WIDTH-1:0] rgb_q, rgb_d;
  logic                    pass_q, pass_d;
  logic                    dout_q;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    bit_ok, bit_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rgb_q     <= '0;
      pass_q    <= 1'b0;
      dout_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rgb_q     <= rgb_d;
      pass_q    <= pass_d;
      dout_q    <= pass_q & din_s;
      valid_q   <= valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // One counter serves as low-time counter in IDLE/LOW and high-time counter in HIGH.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rgb_d     = rgb_q;
    pass_d    = pass_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    bit_ok    = 1'b0;
    bit_val   = 1'b0;
    cnt_inc   = cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (din_s) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(DELAY_RESET)) state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (din_s) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q != CNT_W'(DELAY_RESET)) begin
          // Counter parks at DELAY_RESET so the frame end fires only once.
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(DELAY_RESET)) begin
            done_d    = (bit_cnt_q != '0);
            bit_cnt_d = '0;
            pass_d    = 1'b0;
          end
        end
      end
      ST_HIGH: begin
        if (din_s) begin
          if (cnt_inc >= CNT_W'(T_HIGH_MAX)) begin
            err_d     = 1'b1;
            bit_cnt_d = '0;
            pass_d    = 1'b0;
            state_d   = ST_IDLE;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = ST_LOW;
          cnt_d   = CNT_W'(1);
          if (cnt_q >= CNT_W'(T_GLITCH)) begin
            bit_ok  = 1'b1;
            bit_val = (cnt_q > CNT_W'(T_BIT_THRESH));
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (bit_ok && (bit_cnt_q != BIT_W'(WS2812_WIDTH))) begin
      shift_d[bit_cnt_q] = bit_val;
      bit_cnt_d          = bit_cnt_q + BIT_W'(1);
      if (bit_cnt_q == BIT_W'(WS2812_WIDTH - 1)) begin
        rgb_d   = shift_d;
        valid_d = 1'b1;
        pass_d  = 1'b1;
      end
    end
  end

  assign dout       = dout_q;
  assign rgb_data   = rgb_q;
  assign data_valid = valid_q;
  assign frame_done = done_q;
  assign bit_err    = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx: stimulus pushes expected events, a monitor pops and compares.
module tb_ws2812_rx;

  typedef struct {
    logic [23:0] word;
    longint      t;
  } exp_valid_t;

  typedef struct {
    longint t;
    int     width;
  } exp_fwd_t;

  logic        clk;
  logic        rst;
  logic        din;
  logic        dout;
  logic [23:0] rgb_data;
  logic        data_valid;
  logic        frame_done;
  logic        bit_err;

  int checks   = 0;
  int failures = 0;

  exp_valid_t exp_valid_q[$];
  exp_fwd_t   exp_fwd_q[$];
  int         exp_done_q[$];
  int         exp_err_q[$];

  logic [23:0] fwd_word = '0;
  int          fwd_n    = 0;

  ws2812_rx dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .dout       (dout),
    .rgb_data   (rgb_data),
    .data_valid (data_valid),
    .frame_done (frame_done),
    .bit_err    (bit_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h (%0d) required 0x%0h (%0d) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got unexpected pulse required none at %0t", name, $time);
  endtask

  // Monitor: samples DUT outputs on the falling edge, away from the active edge.
  initial begin : monitor
    logic     dout_prev;
    int       run;
    int       cur_w;
    exp_fwd_t ef;
    exp_valid_t ev;
    dout_prev = 1'b0;
    run       = 0;
    cur_w     = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (data_valid) begin
          if (exp_valid_q.size() == 0) unexpected("data_valid");
          else begin
            ev = exp_valid_q.pop_front();
            chk("rgb_word", longint'(rgb_data), longint'(ev.word));
            chk("valid_time", longint'($time), ev.t);
          end
        end
        if (frame_done) begin
          if (exp_done_q.size() == 0) unexpected("frame_done");
          else void'(exp_done_q.pop_front());
        end
        if (bit_err) begin
          if (exp_err_q.size() == 0) unexpected("bit_err");
          else void'(exp_err_q.pop_front());
        end
        if (dout && !dout_prev) begin
          if (exp_fwd_q.size() == 0) begin
            unexpected("dout");
            cur_w = -1;
          end else begin
            ef    = exp_fwd_q.pop_front();
            cur_w = ef.width;
            chk("dout_rise_time", longint'($time), ef.t);
          end
          run = 0;
        end
        if (dout) run++;
        if (!dout && dout_prev) begin
          if (cur_w >= 0) chk("dout_width", longint'(run), longint'(cur_w));
          if (fwd_n < 24) fwd_word[fwd_n] = (run > 16);
          fwd_n++;
        end
        dout_prev = dout;
      end else begin
        dout_prev = 1'b0;
      end
    end
  end

  task automatic drive(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int h, input int l);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  // Sends n bits of w LSB first; optionally expects forwarding and/or a capture of exp_w.
  task automatic send_bits(input logic [23:0] w, input int n, input bit fwd,
                           input bit vld, input logic [23:0] exp_w);
    logic [23:0] wv;
    exp_fwd_t    ef;
    exp_valid_t  ev;
    int          h;
    int          l;
    wv = w;
    for (int k = 0; k < n; k++) begin
      h = wv[k] ? 22 : 11;
      l = wv[k] ? 11 : 22;
      if (fwd) begin
        ef.t     = longint'($time) + 30;
        ef.width = h;
        exp_fwd_q.push_back(ef);
      end
      drive(1'b1, h);
      din = 1'b0;
      if (vld && (k == n - 1)) begin
        ev.word = exp_w;
        ev.t    = longint'($time) + 30;
        exp_valid_q.push_back(ev);
      end
      repeat (l) @(negedge clk);
    end
  endtask

  task automatic frame_end(input bit expect_done);
    if (expect_done) exp_done_q.push_back(1);
    drive(1'b0, 1400);
  endtask

  initial begin : stim
    din = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_dout", longint'(dout), 0);
    chk("reset_rgb", longint'(rgb_data), 0);
    chk("reset_valid", longint'(data_valid), 0);
    chk("reset_done", longint'(frame_done), 0);
    chk("reset_err", longint'(bit_err), 0);
    rst = 1'b0;

    // Basic capture
    drive(1'b0, 1400);
    send_bits(24'h00000F, 24, 1'b0, 1'b1, 24'h00000F);
    frame_end(1'b1);
    chk("basic_rgb_hold", longint'(rgb_data), 24'h00000F);

    // Capture then forward
    send_bits(24'hA5A5A5, 24, 1'b0, 1'b1, 24'hA5A5A5);
    send_bits(24'h123456, 24, 1'b1, 1'b0, 24'h0);
    frame_end(1'b1);
    chk("fwd_rgb", longint'(rgb_data), 24'hA5A5A5);
    chk("fwd_count", longint'(fwd_n), 24);
    chk("fwd_word", longint'(fwd_word), 24'h123456);

    // Thresholds: 16 -> 0, 17 -> 1, 2 -> glitch
    pulse(16, 22);
    pulse(17, 22);
    pulse(2, 20);
    send_bits(24'hFFFFFF, 22, 1'b0, 1'b1, 24'hFFFFFE);
    frame_end(1'b1);
    chk("thresh_rgb", longint'(rgb_data), 24'hFFFFFE);

    // Over-long high
    send_bits(24'h00001F, 5, 1'b0, 1'b0, 24'h0);
    exp_err_q.push_back(1);
    pulse(60, 22);
    send_bits(24'hFFFFFF, 24, 1'b0, 1'b0, 24'h0);
    frame_end(1'b0);
    chk("err_rgb_hold", longint'(rgb_data), 24'hFFFFFE);
    send_bits(24'h5A5A5A, 24, 1'b0, 1'b1, 24'h5A5A5A);
    frame_end(1'b1);

    // Short frame
    send_bits(24'h0003FF, 10, 1'b0, 1'b0, 24'h0);
    frame_end(1'b1);
    chk("short_rgb_hold", longint'(rgb_data), 24'h5A5A5A);

    // Mid-frame reset during bit 12
    send_bits(24'hFFFFFF, 12, 1'b0, 1'b0, 24'h0);
    din = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    din = 1'b0;
    #1;
    chk("rst_dout", longint'(dout), 0);
    chk("rst_rgb", longint'(rgb_data), 0);
    chk("rst_valid", longint'(data_valid), 0);
    chk("rst_done", longint'(frame_done), 0);
    chk("rst_err", longint'(bit_err), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 5);
    send_bits(24'hFFFFFF, 24, 1'b0, 1'b0, 24'h0);
    frame_end(1'b0);
    chk("post_rst_rgb", longint'(rgb_data), 0);
    send_bits(24'h3C3C3C, 24, 1'b0, 1'b1, 24'h3C3C3C);
    frame_end(1'b1);
    chk("post_rst_capture", longint'(rgb_data), 24'h3C3C3C);

    drive(1'b0, 20);
    chk("pending_valid", longint'(exp_valid_q.size()), 0);
    chk("pending_done", longint'(exp_done_q.size()), 0);
    chk("pending_err", longint'(exp_err_q.size()), 0);
    chk("pending_fwd", longint'(exp_fwd_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
